fft_output_reorder: RTL and testbench

FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

---
 rtl/fft_output_reorder.sv | 146 ++++++++++++++
 tb/tb_fft_output_reorder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_output_reorder
//  Purpose  : Turns the two-path, bit-reversed output of a 32-point MDC FFT
//             into a single natural-order serial stream. Two ping-pong banks
//             of 32 complex entries decouple the write and read sides.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_output_reorder #(
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // dual-path input, bit-reversed frame order
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_up_re,
    input  logic signed [WIDTH-1:0] in_up_im,
    input  logic signed [WIDTH-1:0] in_lo_re,
    input  logic signed [WIDTH-1:0] in_lo_im,
    // serial output, natural bin order
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic [4:0]              out_idx,
    output logic                    out_last
);

    localparam int         c_NUM_BANKS = 2;
    localparam logic [3:0] c_LAST_BEAT = 4'd15;
    localparam logic [4:0] c_LAST_BIN  = 5'd31;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [3:0]             r_wr_cnt;
    logic                   r_wr_bank;
    logic [4:0]             r_rd_cnt;
    logic                   r_rd_bank;
    logic [c_NUM_BANKS-1:0] r_full;

    // Storage word packs {re, im}; address is {bank, bin}
    logic [2*WIDTH-1:0]     r_mem [0:63];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_wr_last;
    logic                   w_rd_last;
    logic [4:0]             w_up_addr;
    logic [4:0]             w_lo_addr;
    logic [2*WIDTH-1:0]     w_rd_word;

    // Handshakes depend only on registered full flags, so in_ready never
    // reacts combinationally to out_ready.
    assign in_ready   = ~r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];
    assign w_in_fire  = in_valid  & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_wr_last  = (r_wr_cnt == c_LAST_BEAT);
    assign w_rd_last  = (r_rd_cnt == c_LAST_BIN);

    // Beat k carries bin bitrev5(k) on the upper path; bitrev5 of a 4-bit
    // count always has a zero LSB, so the lower path lands on the odd bin.
    assign w_up_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3], 1'b0};
    assign w_lo_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3], 1'b1};

    assign w_rd_word = r_mem[{r_rd_bank, r_rd_cnt}];

    // Outputs are forced to zero whenever no sample is being offered.
    always_comb begin
        out_re   = '0;
        out_im   = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_re   = w_rd_word[2*WIDTH-1:WIDTH];
            out_im   = w_rd_word[WIDTH-1:0];
            out_idx  = r_rd_cnt;
            out_last = w_rd_last;
        end
    end

    // Bank storage: both paths of an accepted beat are written in one edge.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[{r_wr_bank, w_up_addr}] <= {in_up_re, in_up_im};
            r_mem[{r_wr_bank, w_lo_addr}] <= {in_lo_re, in_lo_im};
        end
    end

    // Write side: beat counter and bank pointer, advancing per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_in_fire) begin
            r_wr_cnt <= r_wr_cnt + 4'd1;
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Read side: bin counter and bank pointer, advancing per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_out_fire) begin
            r_rd_cnt <= r_rd_cnt + 5'd1;
            if (w_rd_last) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Per-bank full flag. Set and clear can never target the same bank in
    // one edge (writing needs it empty, reading needs it full), so a write
    // finishing into one bank and a read releasing the other both take effect.
    generate
        for (genvar b = 0; b < c_NUM_BANKS; b++) begin : g_bank_full
            logic w_set;
            logic w_clr;

            assign w_set = w_in_fire  & w_wr_last & (r_wr_bank == 1'(b));
            assign w_clr = w_out_fire & w_rd_last & (r_rd_bank == 1'(b));

            // Full flag for bank b
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full[b] <= 1'b0;
                end else if (w_set) begin
                    r_full[b] <= 1'b1;
                end else if (w_clr) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_output_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_output_reorder
//  Purpose  : Self-checking bench for fft_output_reorder with a frame-level
//             reference model (bit-reversed beats -> natural-order queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_output_reorder;

    localparam int c_W = 9;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  in_ready;
    logic signed [c_W-1:0] in_up_re  = '0;
    logic signed [c_W-1:0] in_up_im  = '0;
    logic signed [c_W-1:0] in_lo_re  = '0;
    logic signed [c_W-1:0] in_lo_im  = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [c_W-1:0] out_re;
    logic signed [c_W-1:0] out_im;
    logic [4:0]            out_idx;
    logic                  out_last;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fft_output_reorder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_up_re  (in_up_re),
        .in_up_im  (in_up_im),
        .in_lo_re  (in_lo_re),
        .in_lo_im  (in_lo_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of expected natural-order samples
    // ------------------------------------------------------------------
    typedef struct {
        int re;
        int im;
        int idx;
    } samp_t;

    samp_t exp_q[$];
    int    part_re [32];
    int    part_im [32];
    int    part_k = 0;
    int    held;
    bit    e_in_ready;
    bit    e_valid;
    samp_t s;

    function automatic int bitrev5(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++)
            if (((v >> b) & 1) != 0) r = r + (1 << (4 - b));
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every cycle, then advances the model by the
    // handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_k = 0;
            check("reset_outputs_zero",
                  int'({out_valid, out_last, out_idx}) | int'(out_re) | int'(out_im), 0);
        end else begin
            held       = (exp_q.size() + 31) / 32;
            e_in_ready = (held < 2);
            e_valid    = (exp_q.size() > 0);
            check("in_ready", int'(in_ready), int'(e_in_ready));
            check("out_valid", int'(out_valid), int'(e_valid));
            if (e_valid) begin
                check("out_re", int'(out_re), exp_q[0].re);
                check("out_im", int'(out_im), exp_q[0].im);
                check("out_idx", int'(out_idx), exp_q[0].idx);
                check("out_last", int'(out_last), int'(exp_q[0].idx == 31));
            end else begin
                check("idle_outputs_zero",
                      int'({out_last, out_idx}) | int'(out_re) | int'(out_im), 0);
            end
            if (e_valid && out_ready) void'(exp_q.pop_front());
            if (in_valid && e_in_ready) begin
                part_re[bitrev5(part_k)]     = int'(in_up_re);
                part_im[bitrev5(part_k)]     = int'(in_up_im);
                part_re[bitrev5(part_k) + 1] = int'(in_lo_re);
                part_im[bitrev5(part_k) + 1] = int'(in_lo_im);
                part_k++;
                if (part_k == 16) begin
                    for (int i = 0; i < 32; i++) begin
                        s.re  = part_re[i];
                        s.im  = part_im[i];
                        s.idx = i;
                        exp_q.push_back(s);
                    end
                    part_k = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // out_ready driver: 0 = always high, 1 = random 50%, 2 = held low
    // ------------------------------------------------------------------
    int or_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic beat(input int ur, input int ui, input int lr, input int li);
        bit acc    = 1'b0;
        int budget = 0;
        in_valid = 1'b1;
        in_up_re = c_W'(ur);
        in_up_im = c_W'(ui);
        in_lo_re = c_W'(lr);
        in_lo_im = c_W'(li);
        while (!acc && budget < 500) begin
            @(negedge clk);
            acc = in_ready;
            step();
            budget++;
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL beat_timeout: in_ready stayed 0, required 1");
        end
        in_valid = 1'b0;
    endtask

    // kind 0: identity (re = bin number), 1: random, 2: negative extremes
    task automatic send_beats(input int kind, input bit gaps, input int n);
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            case (kind)
                0: beat(bitrev5(k), int'($urandom_range(0, 255)),
                        bitrev5(k) + 1, int'($urandom_range(0, 255)));
                1: beat(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                        int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
                default: beat(-256, 255, -256, 255);
            endcase
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d samples left, required 0", exp_q.size());
        end
        repeat (2) step();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n   = 1'b0;
        or_mode = 0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", int'(in_ready), 1);
        check("post_reset_out_valid", int'(out_valid), 0);
        step();

        // Single identity frame: natural order 0..31 right after beat 15
        send_beats(0, 1'b0, 16);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) check("latency_out_valid", int'(out_valid), 1);
            check("ident_out_re", int'(out_re), i);
            check("ident_out_idx", int'(out_idx), i);
            check("ident_out_last", int'(out_last), int'(i == 31));
        end
        @(negedge clk);
        check("ident_done_out_valid", int'(out_valid), 0);
        drain();

        // Four continuous frames at full output rate
        send_beats(1, 1'b0, 64);
        drain();

        // Output stalled: two frames fill both banks, third frame is ignored
        or_mode = 2;
        repeat (2) step();
        send_beats(1, 1'b0, 32);
        @(negedge clk);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_idx", int'(out_idx), 0);
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_up_re = c_W'($urandom);
            in_lo_re = c_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_hold_out_idx", int'(out_idx), 0);
        check("stall_hold_out_valid", int'(out_valid), 1);
        or_mode = 1;
        drain();

        // Random in_valid gaps with random out_ready
        send_beats(1, 1'b1, 96);
        drain();

        // Reset in the middle of a frame
        or_mode = 0;
        send_beats(1, 1'b0, 8);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        step();
        send_beats(0, 1'b0, 16);
        @(negedge clk);
        check("after_reset_first_idx", int'(out_idx), 0);
        check("after_reset_first_re", int'(out_re), 0);
        drain();

        // Negative / positive extremes
        send_beats(2, 1'b0, 16);
        @(negedge clk);
        check("extreme_out_re", int'(out_re), -256);
        check("extreme_out_im", int'(out_im), 255);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finished");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1);
    end

endmodule
`default_nettype wire
